// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, port IDs and default widths.
package mem_arb_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 32;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_SETUP,
      WR_STROBE,
      WR_HOLD
   } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: a tie goes to whichever port was not granted last.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last,
   output logic grant
);

   always_comb begin
      grant = PORT_D;
      if (i_req && d_req) begin
         grant = (last == PORT_D) ? PORT_I : PORT_D;
      end else if (i_req) begin
         grant = PORT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single asynchronous RAM.
// Define MEM_ARBITER_RR_EN for round-robin ties; otherwise the data port has fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_read_n,
   output logic              ram_write,
   output logic              ram_oe,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wdata_en,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t state, state_next;
   logic   gnt_port, cur_port, last_grant;
   logic   any_req, grant_we, rd_next, wr_next;

   assign any_req  = i_req | d_req;
   assign grant_we = (gnt_port == PORT_D) && d_we;

`ifdef MEM_ARBITER_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= PORT_D;
      end else if (state == IDLE && any_req) begin
         last_grant <= gnt_port;
      end
   end
`else
   // Pretending I was granted last makes every tie resolve to D.
   assign last_grant = PORT_I;
`endif

   mem_arb_pick u_pick (
      .i_req (i_req),
      .d_req (d_req),
      .last  (last_grant),
      .grant (gnt_port)
   );

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:      if (any_req) state_next = grant_we ? WR_SETUP : RD_ADDR;
         RD_ADDR:   state_next = RD_DATA;
         RD_DATA:   state_next = IDLE;
         WR_SETUP:  state_next = WR_STROBE;
         WR_STROBE: state_next = WR_HOLD;
         WR_HOLD:   state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   assign rd_next = (state_next == RD_ADDR) || (state_next == RD_DATA);
   assign wr_next = (state_next == WR_SETUP) || (state_next == WR_STROBE) ||
                    (state_next == WR_HOLD);

   // RAM controls are registered from the next state so they are glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cur_port     <= PORT_D;
         i_ack        <= 1'b0;
         d_ack        <= 1'b0;
         i_rdata      <= '0;
         d_rdata      <= '0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         ram_read_n   <= 1'b1;
         ram_write    <= 1'b0;
         ram_oe       <= 1'b0;
         ram_wdata_en <= 1'b0;
      end else begin
         state        <= state_next;
         i_ack        <= 1'b0;
         d_ack        <= 1'b0;
         ram_read_n   <= !rd_next;
         ram_oe       <= rd_next;
         ram_wdata_en <= wr_next;
         ram_write    <= (state_next == WR_STROBE);
         case (state)
            IDLE: begin
               if (any_req) begin
                  cur_port <= gnt_port;
                  ram_addr <= (gnt_port == PORT_D) ? d_addr : i_addr;
                  if (grant_we) ram_wdata <= d_wdata;
               end
            end
            RD_DATA: begin
               if (cur_port == PORT_D) begin
                  d_rdata <= ram_rdata;
                  d_ack   <= 1'b1;
               end else begin
                  i_rdata <= ram_rdata;
                  i_ack   <= 1'b1;
               end
            end
            WR_HOLD: d_ack <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule
